// File: rtl/muldiv_seq_if.sv
// Request/response and shared-ALU signals between the EX stage and the
// multi-cycle MUL/DIVU/REMU sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] alu_srca;
    logic [XLEN-1:0] alu_srcb;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;

    modport slave (
        input  start, op, a, b, alu_result,
        output busy, done, result, alu_srca, alu_srcb, alu_ctrl
    );

    modport master (
        output start, op, a, b, alu_result,
        input  busy, done, result, alu_srca, alu_srcb, alu_ctrl
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL (low word), DIVU and REMU built on the shared ALU:
// shift-add multiply and restoring divide, one ALU operation per cycle.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_CMP,
        S_DIV_SUB,
        S_DONE
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_GEU = 4'b1010;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic            ge_q, ge_d;
    logic            is_rem_q, is_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] sh_w;
    logic            last_iter;

    assign sh_w      = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sh_q     <= '0;
            ge_q     <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            sh_q     <= sh_d;
            ge_q     <= ge_d;
            is_rem_q <= is_rem_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        div_d        = div_q;
        sh_d         = sh_q;
        ge_d         = ge_q;
        is_rem_d     = is_rem_q;
        result_d     = result_q;
        bus.alu_srca = '0;
        bus.alu_srcb = '0;
        bus.alu_ctrl = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    case (bus.op)
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = bus.a;
                            mplier_d = bus.b;
                            state_d  = S_MUL;
                        end
                        OP_DIVU, OP_REMU: begin
                            rem_d    = '0;
                            quo_d    = bus.a;
                            div_d    = bus.b;
                            is_rem_d = (bus.op == OP_REMU);
                            state_d  = S_DIV_CMP;
                        end
                        default: begin
                            result_d = '0;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end

            S_MUL: begin
                bus.alu_srca = acc_q;
                bus.alu_srcb = mplier_q[0] ? mcand_q : '0;
                bus.alu_ctrl = ALU_ADD;
                acc_d        = bus.alu_result;
                mcand_d      = mcand_q << 1;
                mplier_d     = mplier_q >> 1;
                cnt_d        = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = bus.alu_result;
                    state_d  = S_DONE;
                end
            end

            // A set rem MSB means the 33-bit shifted remainder beats any divisor.
            S_DIV_CMP: begin
                bus.alu_srca = sh_w;
                bus.alu_srcb = div_q;
                bus.alu_ctrl = ALU_GEU;
                ge_d         = rem_q[XLEN-1] | bus.alu_result[0];
                sh_d         = sh_w;
                state_d      = S_DIV_SUB;
            end

            S_DIV_SUB: begin
                bus.alu_srca = sh_q;
                bus.alu_srcb = ge_q ? div_q : '0;
                bus.alu_ctrl = ALU_SUB;
                rem_d        = bus.alu_result;
                quo_d        = {quo_q[XLEN-2:0], ge_q};
                cnt_d        = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d = is_rem_q ? bus.alu_result : quo_d;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_DIV_CMP;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed scoreboard bench for muldiv_seq with a behavioural
// ALU on the ALU port and an arithmetic reference model.
module tb_muldiv_seq;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural shared ALU answering in the same cycle.
    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_result = bus.alu_srca + bus.alu_srcb;
            4'b0001: bus.alu_result = bus.alu_srca - bus.alu_srcb;
            4'b1010: bus.alu_result = {31'b0, (bus.alu_srca >= bus.alu_srcb)};
            default: bus.alu_result = 32'h0;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          k;
    logic [31:0] last_res = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] refModel(input logic [1:0] op_i, input logic [31:0] a_i,
                                             input logic [31:0] b_i);
        logic [63:0] prod;
        case (op_i)
            2'b00: begin
                prod = 64'(a_i) * 64'(b_i);
                return prod[31:0];
            end
            2'b01:   return (b_i == 0) ? 32'hFFFF_FFFF : a_i / b_i;
            2'b10:   return (b_i == 0) ? a_i : a_i % b_i;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int refLatency(input logic [1:0] op_i);
        case (op_i)
            2'b00:   return 32;
            2'b01:   return 64;
            2'b10:   return 64;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_wait: got busy=%0b, expected busy=0", bus.busy);
            return;
        end
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.start = 1'b1;
        e.op  = op_i;
        e.res = refModel(op_i, a_i, b_i);
        e.acc = cyc + 1;
        e.lat = refLatency(op_i);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulseStart(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        @(negedge clk);
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Monitor: pops the scoreboard on done and polices the ALU port every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
                checkOutput("done_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
                checkOutput("done_alu_src", bus.alu_srca | bus.alu_srcb, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
                end else begin
                    k = cyc - sb[0].acc;
                    checkOutput($sformatf("result_op%0d", sb[0].op), bus.result, sb[0].res);
                    checkOutput($sformatf("latency_op%0d", sb[0].op), 32'(k), 32'(sb[0].lat));
                    last_res = sb[0].res;
                    void'(sb.pop_front());
                end
            end else if (bus.busy) begin
                if (sb.size() > 0) begin
                    k = cyc - sb[0].acc;
                    if (k > sb[0].lat + 4) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL timeout: got no done after %0d cycles, expected %0d", k, sb[0].lat);
                        void'(sb.pop_front());
                    end else if (sb[0].op == 2'b00) begin
                        checkOutput("mul_alu_ctrl", 32'(bus.alu_ctrl), 32'h0);
                    end else begin
                        checkOutput("div_alu_ctrl", 32'(bus.alu_ctrl), (k % 2 == 0) ? 32'hA : 32'h1);
                    end
                end
            end else begin
                checkOutput("idle_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
                checkOutput("idle_alu_src", bus.alu_srca | bus.alu_srcb, 32'd0);
                checkOutput("idle_result_hold", bus.result, last_res);
            end
        end
    end

    logic [1:0]  dir_op[14] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3,
                                2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] dir_a[14]  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd100, 32'd100,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd123, 32'd123, 32'd55,
                                32'd0, 32'd5, 32'd5, 32'd9};
    logic [31:0] dir_b[14]  = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd7,
                                32'h8000_0001, 32'h8000_0001, 32'd0, 32'd0, 32'd66,
                                32'd12345, 32'd9, 32'd9, 32'd1};

    initial begin
        int guard;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        checkOutput("reset_alu_src", bus.alu_srca | bus.alu_srcb, 32'd0);
        #2 reset = 1'b0;

        for (int i = 0; i < 14; i++) applyStimulus(dir_op[i], dir_a[i], dir_b[i]);

        applyStimulus(2'b00, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        pulseStart(2'b01, 32'd99, 32'd3);

        applyStimulus(2'b01, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_done", 32'(bus.done), 32'd0);
        checkOutput("midreset_result", bus.result, 32'd0);
        sb.delete();
        last_res = 32'h0;
        @(negedge clk);
        #2 reset = 1'b0;
        applyStimulus(2'b00, 32'd300, 32'd500);

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = 32'($urandom_range(0, 15));
            if (i % 7 == 3) rb = 32'h0;
            applyStimulus(2'($urandom_range(0, 3)), ra, rb);
        end

        guard = 0;
        while ((sb.size() != 0 || bus.busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
